// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer read path: default geometry, pixel width,
// scan state encoding and the bit positions of the per-pixel marker tags.
package fb_pkg;

  localparam int H_RES_DEF    = 1280;
  localparam int V_RES_DEF    = 720;
  localparam int FB_ADDR_BITS = 20;
  localparam int PIX_W        = 16;

  localparam int TAG_W   = 3;
  localparam int TAG_SOF = 0;
  localparam int TAG_EOL = 1;
  localparam int TAG_EOF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } fb_state_e;

  // Counter width that can hold values 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_rd_fifo.sv
// Small synchronous FIFO holding captured pixels plus marker tags; head is visible combinationally.
// Push and pop in the same cycle leave the count unchanged; the caller reserves space before pushing.
module fb_rd_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_buffer_scan_reader.sv
// Raster-order frame buffer reader; FB_READER_HMIRROR_EN adds an hmirror input for right-to-left lines.
// Read data lands one cycle after rd_en; issue stalls when FIFO occupancy plus the in-flight read fills FIFO_DEPTH.
module frame_buffer_scan_reader
  import fb_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int ADDR_BITS  = FB_ADDR_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef FB_READER_HMIRROR_EN
  input  logic                 hmirror,
`endif
  input  logic                 frame_start,
  input  logic                 fb_ready,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [PIX_W-1:0]     rd_data,
  output logic [PIX_W-1:0]     pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_sof,
  output logic                 pix_eol,
  output logic                 pix_eof,
  output logic                 busy
);

  localparam int XW = idx_w(H_RES);
  localparam int YW = idx_w(V_RES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = PIX_W + TAG_W;

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  fb_state_e state_q, state_d;

  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] addr_nxt;
  logic [ADDR_BITS-1:0] addr_init;
  logic                 inflight_q;
  logic [TAG_W-1:0]     tag_q;
  logic [TAG_W-1:0]     tag_now;
  logic                 line_end;
  logic                 frame_end;
  logic                 room;
  logic                 issue;
  logic                 start_frame;

  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [FW-1:0]        fifo_head;

  assign line_end    = (x_q == X_LAST);
  assign frame_end   = line_end && (y_q == Y_LAST);
  assign start_frame = (state_q == IDLE) && frame_start;

  // x counts in output order, so markers are correct whichever way the line is walked.
  always_comb begin
    tag_now          = '0;
    tag_now[TAG_SOF] = (x_q == '0) && (y_q == '0);
    tag_now[TAG_EOL] = line_end;
    tag_now[TAG_EOF] = frame_end;
  end

`ifdef FB_READER_HMIRROR_EN
  logic mirror_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mirror_q <= 1'b0;
    end else if (start_frame) begin
      mirror_q <= hmirror;
    end
  end

  // Mirrored lines walk downward; at the line's last pixel jump to the far end of the next line.
  always_comb begin
    addr_init = hmirror ? ADDR_BITS'(H_RES - 1) : '0;
    if (mirror_q) begin
      addr_nxt = line_end ? (addr_q + ADDR_BITS'(2 * H_RES - 1)) : (addr_q - ADDR_BITS'(1));
    end else begin
      addr_nxt = addr_q + ADDR_BITS'(1);
    end
  end
`else
  assign addr_init = '0;
  assign addr_nxt  = addr_q + ADDR_BITS'(1);
`endif

  assign room = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        issue = fb_ready && room;
        if (issue && frame_end) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_q <= tag_now;
      end
      if (start_frame) begin
        x_q    <= '0;
        y_q    <= '0;
        addr_q <= addr_init;
      end else if (issue && !frame_end) begin
        // The final address is held so nothing past the frame ever appears on rd_addr.
        addr_q <= addr_nxt;
        if (line_end) begin
          x_q <= '0;
          y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  fb_rd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({rd_data, tag_q}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rd_en     = issue;
  assign rd_addr   = addr_q;
  assign pix_valid = !fifo_empty;
  assign fifo_pop  = pix_valid && pix_ready;

  // Head storage is not reset, so outputs are masked to zero while nothing is queued.
  assign pix_data = pix_valid ? fifo_head[FW-1:TAG_W] : '0;
  assign pix_sof  = pix_valid && fifo_head[TAG_SOF];
  assign pix_eol  = pix_valid && fifo_head[TAG_EOL];
  assign pix_eof  = pix_valid && fifo_head[TAG_EOF];
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_frame_buffer_scan_reader.sv
// Bench for frame_buffer_scan_reader on a 4x3 frame with a buffer model returning the address as data.
// Scenario table drives pacing variations; a scoreboard checks every accepted pixel and every issued address.
module tb_frame_buffer_scan_reader;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AB = 12;
  localparam int FD = 4;

  logic          clk;
  logic          rst;
  logic          frame_start;
  logic          fb_ready;
  logic          rd_en;
  logic [AB-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic [15:0]   pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;
  logic          busy;
`ifdef FB_READER_HMIRROR_EN
  logic          hmirror;
`endif

  frame_buffer_scan_reader #(
    .H_RES      (H),
    .V_RES      (V),
    .ADDR_BITS  (AB),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef FB_READER_HMIRROR_EN
    .hmirror     (hmirror),
`endif
    .frame_start (frame_start),
    .fb_ready    (fb_ready),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer model: returns the address as data, 0x0000 when not read.
  always @(posedge clk) begin
    rd_data <= rd_en ? 16'(rd_addr) : 16'h0000;
  end

  typedef struct {
    int ready_mode;  // 0: always ready, 1: 1-0-0-1 pattern
    int gap_addr;    // address after which fb_ready drops for 5 cycles, -1 none
    bit mid_start;   // extra frame_start while scanning
    bit mirror;
    int exp_pix;
    int exp_last;
    int exp_span;    // cycles from first to last pixel, -1 unchecked
  } vec_t;

  vec_t        vecs[$];
  logic [18:0] sb[$];
  int          exp_addr[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int n_iss = 0;
  int n_pop = 0;
  int mon_cyc = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  int scen_pop_base = 0;
  int ready_mode = 0;
  int gap_addr = -1;
  int gap_cnt = 0;
  int drv_cyc = 0;
  int last_data = -1;
  bit prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: event missing", name);
  endtask

  task automatic push_frame(input bit mirror);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        int a;
        bit sof, eol, eof;
        a   = y * H + (mirror ? (H - 1 - x) : x);
        sof = (x == 0) && (y == 0);
        eol = (x == H - 1);
        eof = eol && (y == V - 1);
        sb.push_back({16'(a), sof, eol, eof});
        exp_addr.push_back(a);
      end
    end
  endtask

  // Input pacing: pix_ready pattern and fb_ready gaps, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      drv_cyc++;
      pix_ready = (ready_mode == 0) ? 1'b1 : ((drv_cyc % 4 == 0) || (drv_cyc % 4 == 3));
      fb_ready  = (gap_cnt == 0);
      if (gap_cnt > 0) gap_cnt--;
    end
  end

  always @(negedge clk) begin
    mon_cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (!fb_ready) check("no_rd_while_not_ready", rd_en, 1'b0);
      if (rd_en) begin
        check("occupancy_limit", (n_iss - n_pop) < FD, 1'b1);
        if (exp_addr.size() == 0) fail_now("unexpected_rd_en");
        else check("rd_addr", rd_addr, exp_addr.pop_front());
        if (gap_addr >= 0 && int'(rd_addr) == gap_addr) gap_cnt = 5;
        n_iss++;
      end
      if (prev_stall) begin
        check("stall_valid_held", pix_valid, 1'b1);
        check("stall_data_held", pix_data, prev_data);
      end
      if (pix_valid && pix_ready) begin
        if (sb.size() == 0) fail_now("unexpected_pixel");
        else check("pixel_data_markers", {pix_data, pix_sof, pix_eol, pix_eof}, sb.pop_front());
        if (n_pop == scen_pop_base) first_pop_cyc = mon_cyc;
        last_pop_cyc = mon_cyc;
        last_data = int'(pix_data);
        n_pop++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit done;
    ready_mode    = v.ready_mode;
    gap_addr      = v.gap_addr;
    scen_pop_base = n_pop;
`ifdef FB_READER_HMIRROR_EN
    hmirror = v.mirror;
`endif
    push_frame(v.mirror);
    pulse_start();
    if (v.mid_start) begin
      repeat (3) @(posedge clk);
      pulse_start();
    end
    done = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check("busy_falls", done, 1'b1);
    check("pixels_at_busy_fall", n_pop - scen_pop_base, v.exp_pix);
    repeat (6) @(negedge clk);
    #1;
    check("pixel_count", n_pop - scen_pop_base, v.exp_pix);
    check("last_pixel", last_data, v.exp_last);
    check("scoreboard_empty", sb.size(), 0);
    check("idle_valid_low", pix_valid, 1'b0);
    if (v.exp_span >= 0) check("back_to_back", last_pop_cyc - first_pop_cyc, v.exp_span);
    ready_mode = 0;
    gap_addr   = -1;
  endtask

  initial begin
    bit seen;
    vecs.push_back('{ready_mode: 0, gap_addr: -1, mid_start: 0, mirror: 0, exp_pix: 12, exp_last: 11, exp_span: 11});
    vecs.push_back('{ready_mode: 1, gap_addr: -1, mid_start: 0, mirror: 0, exp_pix: 12, exp_last: 11, exp_span: -1});
    vecs.push_back('{ready_mode: 0, gap_addr: 5,  mid_start: 0, mirror: 0, exp_pix: 12, exp_last: 11, exp_span: -1});
    vecs.push_back('{ready_mode: 0, gap_addr: -1, mid_start: 1, mirror: 0, exp_pix: 12, exp_last: 11, exp_span: 11});
    vecs.push_back('{ready_mode: 1, gap_addr: 2,  mid_start: 1, mirror: 0, exp_pix: 12, exp_last: 11, exp_span: -1});
`ifdef FB_READER_HMIRROR_EN
    vecs.push_back('{ready_mode: 0, gap_addr: -1, mid_start: 0, mirror: 1, exp_pix: 12, exp_last: 8, exp_span: 11});
    vecs.push_back('{ready_mode: 1, gap_addr: 6,  mid_start: 0, mirror: 1, exp_pix: 12, exp_last: 8, exp_span: -1});
    hmirror = 1'b0;
`endif

    rst         = 1'b1;
    frame_start = 1'b0;
    pix_ready   = 1'b1;
    fb_ready    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rd_en", rd_en, 1'b0);
    check("reset_rd_addr", rd_addr, '0);
    check("reset_pix_valid", pix_valid, 1'b0);
    check("reset_pix_data", pix_data, '0);
    check("reset_markers", {pix_sof, pix_eol, pix_eof}, 3'b000);
    check("reset_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a frame, then a fresh frame from address 0.
    push_frame(1'b0);
    scen_pop_base = n_pop;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (pix_valid && pix_data == 16'd7) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_pixel_7", seen, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_rd_en", rd_en, 1'b0);
    check("midrst_rd_addr", rd_addr, '0);
    check("midrst_pix_valid", pix_valid, 1'b0);
    check("midrst_pix_data", pix_data, '0);
    check("midrst_markers", {pix_sof, pix_eol, pix_eof}, 3'b000);
    check("midrst_busy", busy, 1'b0);
    sb.delete();
    exp_addr.delete();
    n_iss = 0;
    n_pop = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/frame_buffer_scan_reader.md
Name: frame_buffer_scan_reader

Overview:
- Read-side master for the 16-bit frame buffer.
- Scans one full frame in raster order by issuing rd_en/rd_addr pulses to the buffer's read port.
- Captures rd_data one cycle after each issue and presents it as a valid/ready pixel stream with frame and line markers.
- Feeds the HDMI/DVI output path or the distortion-correction stage when they consume the buffered frame sequentially.

Parameters:
- H_RES, 1280, active pixels per line.
- V_RES, 720, active lines per frame.
- ADDR_BITS, 20, read address width; H_RES*V_RES must not exceed 2^ADDR_BITS.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock; frame buffer read port runs on this clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that requests a frame scan.
- fb_ready  in  1  frame buffer valid (frame_buffer_ready).
- rd_en  out  1  read strobe to the frame buffer.
- rd_addr  out  ADDR_BITS  read address, y*H_RES+x.
- rd_data  in  16  buffer read data; valid on the cycle after rd_en.
- pix_data  out  16  RGB565 output pixel.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accept.
- pix_sof  out  1  first pixel of frame; qualified by pix_valid.
- pix_eol  out  1  last pixel of line; qualified by pix_valid.
- pix_eof  out  1  last pixel of frame; qualified by pix_valid.
- busy  out  1  scan in progress or FIFO not empty.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, pix_valid=0, pix_data=0, pix_sof/eol/eof=0, busy=0.
- Reset clears the state machine, counters, in-flight flag and FIFO. Reset mid-frame abandons the scan; no partial frame resumes.
- States:
  - IDLE: frame_start=1 -> SCAN. x, y and linear address are zeroed. frame_start while not IDLE is ignored.
  - SCAN: issues reads while allowed. After the read of address H_RES*V_RES-1 issues -> DRAIN.
  - DRAIN: waits for the in-flight read to land and the FIFO to empty -> IDLE.
- Issue rule: rd_en=1 in a cycle only when all of the following hold:
  - state is SCAN;
  - fb_ready=1;
  - FIFO occupancy + in-flight count < FIFO_DEPTH.
- At most one read is in flight at a time: latency is 1 cycle, and the next cycle may issue again.
- The rd_en=1 cycle is throughput 1 pixel/clk when pix_ready is held high.
- rd_addr is a registered linear counter incremented per issue; no multiplier. x wraps at H_RES-1 and y then increments.
- Each issue carries tag bits {sof, eol, eof}, delayed 1 cycle alongside the in-flight flag:
  - sof is set when x=0 and y=0;
  - eol is set when x=H_RES-1;
  - eof is set when eol=1 and y=V_RES-1.
- Capture: the cycle after rd_en, {rd_data, tags} is written into the FIFO unconditionally. Space was reserved at issue time, so no overflow is possible.
- fb_ready falling mid-scan pauses issue only; the address is held and the scan resumes at the same address when fb_ready returns. An in-flight read is still captured, including the 0x0000 the buffer returns.
- Output: pix_valid = FIFO non-empty, and pix_data/markers come from the FIFO head. A transfer occurs when pix_valid & pix_ready. pix_data is stable while pix_valid=1 and pix_ready=0.
- Simultaneous FIFO push and pop in the same cycle keep occupancy unchanged.
- busy = (state != IDLE).
- No address outside 0..H_RES*V_RES-1 is ever issued.

Optional Feature:
- Macro: FB_READER_HMIRROR_EN.
- Defined: adds input port hmirror (1 bit), sampled at frame_start and held for the whole frame. When the sampled value is 1:
  - each line is read right-to-left, with address y*H_RES+(H_RES-1-x);
  - sof/eol/eof follow output order: first emitted pixel is sof, last pixel emitted per line is eol.
- Undefined: no hmirror port; left-to-right only.

Decomposition:
- Package fb_pkg holds:
  - H_RES_DEF and V_RES_DEF;
  - FB_ADDR_BITS;
  - PIX_W=16;
  - the state encoding (IDLE, SCAN, DRAIN);
  - the tag bit indices (TAG_SOF, TAG_EOL, TAG_EOF).
- One sub-module: fb_rd_fifo, a synchronous FIFO of width 19 (16 data + 3 tags) and depth FIFO_DEPTH, with count output.

Test Plan:
- Basic scan, H_RES=4, V_RES=3, buffer preloaded with addr value, pix_ready=1, one frame_start:
  - 12 pixels 0..11 emerge back-to-back;
  - sof on pixel 0, eol on pixels 3/7/11, eof on pixel 11;
  - busy drops after pixel 11.
- Backpressure, pix_ready toggling 1-0-0-1 repeatedly:
  - no loss or duplicate; output sequence is still 0..11;
  - rd_en never fires when occupancy+inflight=FIFO_DEPTH;
  - pix_data is held while stalled.
- fb_ready dropped for 5 cycles after address 5 issues:
  - no rd_en during the gap;
  - next issue is address 6;
  - stream is contiguous 0..11.
- frame_start pulsed again mid-scan: ignored, and exactly 12 pixels are produced. A second frame_start in IDLE produces a second full frame.
- rst asserted at pixel 7 of a frame:
  - outputs go to reset values immediately;
  - after release, frame_start yields a fresh sequence from 0 with sof.
- With FB_READER_HMIRROR_EN and hmirror=1:
  - output order is 3,2,1,0,7,6,5,4,11,10,9,8;
  - eol on 0/4/8, eof on 8.
